// File: rtl/mux_4x1.sv
// 4-to-1 lane multiplexer with a single registered output (Y) and synchronous active-high reset.
// Optional load enable on Y is built when MUX_4X1_HOLD_EN is defined.
module mux_4x1 #(
    parameter int unsigned DATA_W = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DATA_W-1:0]   in,
    input  logic [1:0]            S,
`ifdef MUX_4X1_HOLD_EN
    input  logic                  en,
`endif
    output logic [DATA_W-1:0]     Y
);

    logic [DATA_W-1:0] Y_q;
    logic [DATA_W-1:0] Y_d;
    logic [DATA_W-1:0] lane_sel;

    always_comb begin
        lane_sel = '0;
        case (S)
            2'd0: lane_sel = in[0*DATA_W +: DATA_W];
            2'd1: lane_sel = in[1*DATA_W +: DATA_W];
            2'd2: lane_sel = in[2*DATA_W +: DATA_W];
            2'd3: lane_sel = in[3*DATA_W +: DATA_W];
            default: lane_sel = '0;
        endcase
    end

    always_comb begin
        Y_d = Y_q;
`ifdef MUX_4X1_HOLD_EN
        if (en) begin
            Y_d = lane_sel;
        end
`else
        Y_d = lane_sel;
`endif
    end

    // Reset wins over any load, including when the hold enable is present.
    always_ff @(posedge clk) begin
        if (rst) begin
            Y_q <= '0;
        end else begin
            Y_q <= Y_d;
        end
    end

    assign Y = Y_q;

endmodule

// File: tb/tb_mux_4x1.sv
// Directed-vector bench for mux_4x1: stimulus pushes the expected Y per edge,
// and a monitor pops and compares one entry after every rising edge.
module tb_mux_4x1;

    localparam int unsigned DW = 1;

    typedef struct {
        logic [DW-1:0] exp;
        string         name;
    } sb_entry_t;

    logic              clk;
    logic              rst;
    logic [4*DW-1:0]   in_v;
    logic [1:0]        S;
    logic              en;
    logic [DW-1:0]     Y;

    sb_entry_t sb_q[$];
    int checks = 0;
    int errors = 0;

    mux_4x1 #(.DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .in  (in_v),
        .S   (S),
`ifdef MUX_4X1_HOLD_EN
        .en  (en),
`endif
        .Y   (Y)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: Y is registered, so one expected value is consumed per edge.
    always @(posedge clk) begin
        sb_entry_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (Y !== e.exp) begin
                errors++;
                $display("FAIL %s: Y=%0h expected %0h", e.name, Y, e.exp);
            end
        end
    end

    // Apply inputs at the falling edge so they are stable for the next rising edge.
    task automatic drive(input logic r, input logic [3:0] i, input logic [1:0] s,
                         input logic e, input logic [DW-1:0] exp, input string name);
        sb_entry_t ent;
        @(negedge clk);
        rst  = r;
        in_v = i;
        S    = s;
        en   = e;
        ent.exp  = exp;
        ent.name = name;
        sb_q.push_back(ent);
    endtask

    task automatic check_now(input logic [DW-1:0] exp, input string name);
        checks++;
        if (Y !== exp) begin
            errors++;
            $display("FAIL %s: Y=%0h expected %0h", name, Y, exp);
        end
    endtask

    initial begin
        rst  = 1'b1;
        in_v = '0;
        S    = 2'b00;
        en   = 1'b1;

        // 1: reset holds Y at 0 even with all lanes high, then releases.
        drive(1'b1, 4'b1111, 2'b11, 1'b1, 1'b0, "reset_edge0");
        drive(1'b1, 4'b1111, 2'b11, 1'b1, 1'b0, "reset_edge1");
        drive(1'b0, 4'b1111, 2'b11, 1'b1, 1'b1, "reset_release");

        // 2: lane0 low, then lane1 high must not appear before the edge.
        drive(1'b0, 4'b0000, 2'b00, 1'b1, 1'b0, "lane0_zero");
        drive(1'b0, 4'b0010, 2'b01, 1'b1, 1'b1, "lane1_one");
        #1;
        check_now(1'b0, "no_comb_path");

        // 3: upper lanes and a select that moves away from the set lane.
        drive(1'b0, 4'b0100, 2'b10, 1'b1, 1'b1, "lane2_one");
        drive(1'b0, 4'b1000, 2'b11, 1'b1, 1'b1, "lane3_one");
        drive(1'b0, 4'b1000, 2'b00, 1'b1, 1'b0, "unsel_lane3");

        // 4: walking one across lanes x selects.
        for (int lane = 0; lane < 4; lane++) begin
            for (int s = 0; s < 4; s++) begin
                logic [3:0] pat;
                logic [1:0] sv;
                pat = 4'b0001 << lane;
                sv  = 2'(s);
                drive(1'b0, pat, sv, 1'b1, (s == lane) ? 1'b1 : 1'b0,
                      $sformatf("walk_l%0d_s%0d", lane, s));
            end
        end

        // 5: reset mid-stream with a selected lane high.
        drive(1'b0, 4'b0001, 2'b00, 1'b1, 1'b1, "pre_midreset");
        drive(1'b1, 4'b1111, 2'b01, 1'b1, 1'b0, "midreset_clear");
        drive(1'b0, 4'b1111, 2'b01, 1'b1, 1'b1, "midreset_resume");

        // Unselected lanes toggling while selected lane stays low.
        drive(1'b0, 4'b1110, 2'b00, 1'b1, 1'b0, "unsel_all_high");
        drive(1'b0, 4'b1011, 2'b10, 1'b1, 1'b0, "unsel_lane2_low");

`ifdef MUX_4X1_HOLD_EN
        // 6: enable low holds Y, enable high reloads, reset ignores enable.
        drive(1'b0, 4'b0010, 2'b01, 1'b1, 1'b1, "hold_load1");
        drive(1'b0, 4'b0000, 2'b01, 1'b0, 1'b1, "hold_keep1");
        drive(1'b0, 4'b0000, 2'b01, 1'b0, 1'b1, "hold_keep1b");
        drive(1'b0, 4'b0000, 2'b01, 1'b1, 1'b0, "hold_load0");
        drive(1'b0, 4'b1111, 2'b11, 1'b1, 1'b1, "hold_load1b");
        drive(1'b1, 4'b1111, 2'b11, 1'b0, 1'b0, "hold_rst_noen");
`endif

        @(negedge clk);
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: pending=%0d expected 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time=%0t expected finish before 100000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
